// File: rtl/cp0_exc_handler_pkg.sv
// Shared CP0 definitions: register indices, ExcCodes, handler entry point,
// and the EPC target computation used when an exception is taken.
package cp0_exc_handler_pkg;

    // CP0 register indices (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // ExcCode values produced by the stage detectors
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exception/interrupt handler entry address
    localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

    // Victim PC rewound to the branch when in a delay slot; 32-bit wrap, word aligned.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? (pc - 32'd4) : pc;
        return t & ~32'h3;
    endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational interrupt/exception arbiter.
// Ports:
//   hwint       - live hardware interrupt lines HW[7:2]
//   im, ie, exl - SR interrupt mask, global enable, exception level
//   exccode_in  - ExcCode of the M-stage victim (0 = none)
//   int_req     - unmasked interrupt pending and allowed
//   exc_req     - synchronous exception pending and allowed
//   exccode_sel - ExcCode to record; interrupt wins over any exception
module cp0_int_arb
    import cp0_exc_handler_pkg::*;
(
    input  logic [5:0] hwint,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exccode_in,
    output logic       int_req,
    output logic       exc_req,
    output logic [4:0] exccode_sel
);

    always_comb begin
        int_req     = (|(hwint & im)) & ie & ~exl;
        exc_req     = (exccode_in != EXC_INT) & ~exl;
        exccode_sel = int_req ? EXC_INT : exccode_in;
    end

endmodule

// File: rtl/cp0_exc_handler.sv
// Coprocessor-0 exception/interrupt responder: holds SR/Cause/EPC/PRId,
// raises req to flush and redirect, and serves mfc0/mtc0/eret.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   a_rd        - mfc0 register index;  dout - mfc0 read data
//   a_wr, we, din - mtc0 index, strobe and data
//   pc_in, bd_in, exccode_in - victim PC, delay-slot flag and ExcCode
//   hwint       - level-sensitive hardware interrupt lines
//   exl_clr     - eret in M stage
//   req         - take exception/interrupt now (combinational)
//   epc_out     - registered EPC for the eret target
module cp0_exc_handler
    import cp0_exc_handler_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_4D49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a_rd,
    input  logic [4:0]  a_wr,
    input  logic        we,
    input  logic [31:0] din,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hwint,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] dout
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;     // [1:0] are held at zero

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exccode_sel;

    cp0_int_arb u_arb (
        .hwint       (hwint),
        .im          (sr_im),
        .ie          (sr_ie),
        .exl         (sr_exl),
        .exccode_in  (exccode_in),
        .int_req     (int_req),
        .exc_req     (exc_req),
        .exccode_sel (exccode_sel)
    );

    assign req     = int_req | exc_req;
    assign epc_out = epc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hwint;
            if (req) begin
                // Taking the exception drops any same-cycle mtc0.
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= exccode_sel;
                epc_q     <= epc_target(pc_in, bd_in);
            end else begin
                if (we) begin
                    case (a_wr)
                        CP0_SR: begin
                            sr_im  <= din[15:10];
                            sr_exl <= din[1];
                            sr_ie  <= din[0];
                        end
                        CP0_EPC: epc_q <= {din[31:2], 2'b00};
                        default: ;
                    endcase
                end
                // eret clear overrides an SR write in the same cycle.
                if (exl_clr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (a_rd)
            CP0_SR:    dout = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            CP0_CAUSE: dout = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID_VAL;
            default:   dout = '0;
        endcase
    end

endmodule
